// File: rtl/led_7seg_mux.sv
// rtl/led_7seg_mux.sv - multiplexed 7-segment driver with frame-synchronous data update
// and leading-zero blanking.
module led_7seg_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [7:0]              sseg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRE = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_hex_q, pend_hex_d, act_hex_q, act_hex_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic                    pend_flag_q, pend_flag_d;
    logic [7:0]              sseg_q, sseg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick, wrap;
    logic [3:0]              nib;
    logic                    dp_sel, lz_run, lz_sel;

    function automatic logic [6:0] seg_decode(input logic [3:0] h);
        case (h)
            4'h0: seg_decode = 7'b1000000;
            4'h1: seg_decode = 7'b1111001;
            4'h2: seg_decode = 7'b0100100;
            4'h3: seg_decode = 7'b0110000;
            4'h4: seg_decode = 7'b0011001;
            4'h5: seg_decode = 7'b0010010;
            4'h6: seg_decode = 7'b0000010;
            4'h7: seg_decode = 7'b1111000;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0010000;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b0000011;
            4'hC: seg_decode = 7'b1000110;
            4'hD: seg_decode = 7'b0100001;
            4'hE: seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    assign tick       = en && (presc_q == LAST_PRE);
    assign wrap       = tick && (idx_q == LAST_IDX);
    assign frame_done = wrap;
    assign sseg       = sseg_q;
    assign an         = an_q;

    always_comb begin
        presc_d = '0;
        idx_d   = '0;
        if (en) begin
            presc_d = (presc_q == LAST_PRE) ? '0 : presc_q + PW'(1);
            idx_d   = idx_q;
            if (tick) begin
                idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            end
        end
    end

    // Pending data lands in active only at a frame wrap (or at once when the scan is idle),
    // so a frame never shows a mix of old and new digits.
    always_comb begin
        pend_hex_d  = pend_hex_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;
        act_hex_d   = act_hex_q;
        act_dp_d    = act_dp_q;
        if (pend_flag_q && (wrap || !en)) begin
            act_hex_d   = pend_hex_q;
            act_dp_d    = pend_dp_q;
            pend_flag_d = 1'b0;
        end
        if (load && wrap) begin
            act_hex_d   = hex_in;
            act_dp_d    = dp_in;
            pend_flag_d = 1'b0;
        end else if (load) begin
            pend_hex_d  = hex_in;
            pend_dp_d   = dp_in;
            pend_flag_d = 1'b1;
        end
    end

    // lz_run stays high while every digit from the top down to k is a plain zero.
    always_comb begin
        nib    = '0;
        dp_sel = 1'b0;
        lz_run = 1'b1;
        lz_sel = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_run = lz_run && (act_hex_q[4*k +: 4] == 4'd0) && !act_dp_q[k];
            if (idx_q == IW'(k)) begin
                nib    = act_hex_q[4*k +: 4];
                dp_sel = act_dp_q[k];
                lz_sel = lz_run && (k != 0);
            end
        end
        an_d   = en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        sseg_d = (!en || (blank_lz && lz_sel)) ? 8'hFF : {~dp_sel, seg_decode(nib)};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pend_hex_q  <= '0;
            pend_dp_q   <= '0;
            pend_flag_q <= 1'b0;
            act_hex_q   <= '0;
            act_dp_q    <= '0;
            sseg_q      <= 8'hFF;
            an_q        <= '1;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pend_hex_q  <= pend_hex_d;
            pend_dp_q   <= pend_dp_d;
            pend_flag_q <= pend_flag_d;
            act_hex_q   <= act_hex_d;
            act_dp_q    <= act_dp_d;
            sseg_q      <= sseg_d;
            an_q        <= an_d;
        end
    end

endmodule

// File: doc/led_7seg_mux.md
LED_7SEG_MUX -- requirements
Module: led_7seg_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000, clock cycles each digit is displayed; legal range >= 2.
REQ-003 Port clock  input  1  single clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  display enable; 0 blanks all outputs and holds the scan at digit 0.
REQ-006 Port load  input  1  one-cycle strobe; captures hex_in/dp_in.
REQ-007 Port hex_in  input  4*NUM_DIGITS  nibble k = digit k; digit 0 is least significant (rightmost).
REQ-008 Port dp_in  input  NUM_DIGITS  bit k = decimal point of digit k, 1 = lit.
REQ-009 Port blank_lz  input  1  1 = leading-zero blanking on.
REQ-010 Port sseg  output  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
REQ-011 Port an  output  NUM_DIGITS  active-low one-hot digit select, registered.
REQ-012 Port frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-013 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick = prescaler at REFRESH_DIV-1 with en=1.
REQ-014 Digit index SHALL advance by 1 on tick, wrapping from NUM_DIGITS-1 to 0.
REQ-015 frame_done SHALL pulse high for exactly one cycle on the tick where index = NUM_DIGITS-1.
REQ-016 With en=0, prescaler and index SHALL be held at 0, an = all 1, sseg = 8'hFF, frame_done = 0.
REQ-017 Data path: load=1 captures hex_in/dp_in into pending registers and sets pending flag; later loads before the copy overwrite pending.
REQ-018 Pending SHALL copy to active registers, and the flag SHALL clear, on the frame-wrap tick (index NUM_DIGITS-1 -> 0); no tearing within a frame.
REQ-019 Load on the same cycle as the frame-wrap tick SHALL write hex_in/dp_in directly to active and leave the flag clear.
REQ-020 With en=0, pending SHALL copy to active on the cycle after load (no frame to wait for).
REQ-021 an/sseg SHALL reflect the index one cycle after it changes (1-cycle registered latency).
REQ-022 an[index] = 0, all other bits 1, while en=1.
REQ-023 Decode (sseg[6:0], g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-024 sseg[7] SHALL equal ~dp of the selected digit.
REQ-025 Digit k (k > 0) is blanked when blank_lz=1 and active nibbles NUM_DIGITS-1..k are all zero and no dp among digits NUM_DIGITS-1..k is set.
REQ-026 Blanked digit: sseg = 8'hFF, an still driven normally; digit 0 is never blanked.
REQ-027 blank_lz and en SHALL take effect without waiting for a frame boundary.

Reset
REQ-028 On reset=1 (asynchronous, any time including mid-frame): prescaler=0, index=0, pending/active=0, pending flag=0, sseg=8'hFF, an=all 1, frame_done=0.
REQ-029 After reset release with en=1, the first tick SHALL occur REFRESH_DIV cycles later; digit 0 is displayed from the second cycle after release.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-030 Reset, en=1, load hex_in=16'h1234, dp_in=0 while en=0 -> an cycles 1110,1101,1011,0111 every 4 cycles; sseg 0011001,0110000,0100100,1111001 per digit; frame_done every 16 cycles.
REQ-031 blank_lz=1, active 16'h0070 -> digits 3 and 2 sseg=8'hFF, digit 1=1111000, digit 0=1000000; then dp_in=4'b1000 loaded -> digit 3 shows 0 with dp (01000000), digit 2 shows 1000000.
REQ-032 Load 16'hABCD mid-frame at index 1 -> remaining digits of that frame still show old data; new data from next index-0 onward.
REQ-033 Load coincident with frame-wrap tick -> new data shown on digit 0 of the immediately following frame; pending flag stays 0.
REQ-034 Drop en mid-frame -> next cycle an=1111, sseg=8'hFF, frame_done=0; re-enable -> scan restarts at digit 0.
REQ-035 Assert reset asynchronously between clock edges mid-frame -> outputs reach reset values before the next clock edge.
